// File: rtl/config_frame_writer.sv
// Write side of the tile configuration-latch interface: one config word per frame row, with setup/strobe/hold sequencing.
// Optional running checksum output enabled by defining CFG_WRITER_CHECKSUM_EN.
module config_frame_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumColumns      = 8,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 1,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [NumColumns-1:0]      ColSelect,
  output logic                       busy,
  output logic                       done
`ifdef CFG_WRITER_CHECKSUM_EN
  ,
  output logic [FrameBitsPerRow-1:0] checksum
`endif
);

  localparam int FW    = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int CW    = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int MaxPh = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CntW  = (MaxPh > 1) ? $clog2(MaxPh) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t                     state_q, state_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic [CW-1:0]              col_q, col_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic                       done_q, done_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [NumColumns-1:0]      colsel_q, colsel_d;
`ifdef CFG_WRITER_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] csum_q, csum_d;
`endif

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      strobe_q <= '0;
      colsel_q <= '0;
`ifdef CFG_WRITER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      colsel_q <= colsel_d;
`ifdef CFG_WRITER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Strobe register is set on SETUP exit and cleared on STROBE exit, so it is high exactly while in STROBE.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    data_d   = data_q;
    strobe_d = strobe_q;
    colsel_d = colsel_q;
`ifdef CFG_WRITER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    if (start && (state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          frame_d = '0;
          col_d   = '0;
        end
      end
      S_WAIT: begin
        if (start) begin
          frame_d = '0;
          col_d   = '0;
        end else if (s_valid) begin
          data_d   = s_data;
          colsel_d = NumColumns'(1) << col_q;
          cnt_d    = '0;
          state_d  = S_SETUP;
`ifdef CFG_WRITER_CHECKSUM_EN
          csum_d   = {csum_q[FrameBitsPerRow-2:0], csum_q[FrameBitsPerRow-1]} ^ s_data;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
          cnt_d    = '0;
          strobe_d = MaxFramesPerCol'(1) << frame_q;
          state_d  = S_STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == CntW'(STROBE_CYCLES - 1)) begin
          cnt_d    = '0;
          strobe_d = '0;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = S_WAIT;
          // A restart request (latched or arriving now) overrides pointer advance and any done pulse.
          if (pend_q || start) begin
            frame_d = '0;
            col_d   = '0;
          end else if (frame_q != FW'(MaxFramesPerCol - 1)) begin
            frame_d = frame_q + 1'b1;
          end else begin
            frame_d = '0;
            if (col_q != CW'(NumColumns - 1)) begin
              col_d = col_q + 1'b1;
            end else begin
              col_d    = '0;
              colsel_d = '0;
              done_d   = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CFG_WRITER_CHECKSUM_EN
    if (start) begin
      csum_d = '0;
    end
`endif
  end

  assign s_ready     = (state_q == S_WAIT);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign ColSelect   = colsel_q;
`ifdef CFG_WRITER_CHECKSUM_EN
  assign checksum    = csum_q;
`endif

endmodule

// File: tb/tb_config_frame_writer.sv
// Scoreboard bench for config_frame_writer: directed words push expected strobe/done events, a monitor pops and compares.
// Checksum checks are active when CFG_WRITER_CHECKSUM_EN is defined.
module tb_config_frame_writer;

  logic        CLK;
  logic        resetn;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [7:0]  ColSelect;
  logic        busy;
  logic        done;
`ifdef CFG_WRITER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  config_frame_writer dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .start       (start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ColSelect   (ColSelect),
    .busy        (busy),
    .done        (done)
`ifdef CFG_WRITER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  typedef struct {
    logic        isDone;
    logic [7:0]  col;
    logic [19:0] strobe;
    logic [31:0] data;
  } ev_t;

  ev_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  expCol = 0;
  int  expFrame = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    expCol = 0;
    expFrame = 0;
  endtask

  // Presents a word and returns 1 time unit after the edge that accepted it (writer then in SETUP).
  task automatic applyStimulus(input logic [31:0] data, input bit expectWrite);
    int n = 0;
    ev_t e;
    s_data  = data;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!s_ready) begin
      checkOutput("accept_timeout", 32'(s_ready), 32'd1);
      return;
    end
    @(posedge CLK); #1;
    if (expectWrite) begin
      e.isDone = 1'b0;
      e.col    = 8'(1) << expCol;
      e.strobe = 20'(1) << expFrame;
      e.data   = data;
      expQ.push_back(e);
      if (expFrame < 19) begin
        expFrame++;
      end else begin
        expFrame = 0;
        if (expCol < 7) begin
          expCol++;
        end else begin
          expCol   = 0;
          e.isDone = 1'b1;
          e.col    = 8'h00;
          e.strobe = 20'h0;
          e.data   = data;
          expQ.push_back(e);
        end
      end
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("idle_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: every strobe cycle or done pulse must match the oldest expected event.
  always @(negedge CLK) begin
    ev_t e;
    if (resetn && (done || FrameStrobe != 20'h0)) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event done=%0b strobe=0x%0h col=0x%0h data=0x%0h required=none",
                 done, FrameStrobe, ColSelect, FrameData);
      end else begin
        e = expQ.pop_front();
        if (e.isDone) begin
          if (done !== 1'b1 || FrameStrobe !== 20'h0 || ColSelect !== 8'h00) begin
            errors++;
            $display("[TB] FAIL done_event done=%0b strobe=0x%0h col=0x%0h required done=1 strobe=0 col=0",
                     done, FrameStrobe, ColSelect);
          end
        end else if (done !== 1'b0 || FrameStrobe !== e.strobe || ColSelect !== e.col || FrameData !== e.data) begin
          errors++;
          $display("[TB] FAIL strobe_event done=%0b strobe=0x%0h col=0x%0h data=0x%0h required strobe=0x%0h col=0x%0h data=0x%0h",
                   done, FrameStrobe, ColSelect, FrameData, e.strobe, e.col, e.data);
        end
      end
    end
  end

  initial begin
    logic [15:0] t;
    logic [19:0] expStrobe;
    resetn  = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_strobe", 32'(FrameStrobe), 32'h0);
    checkOutput("reset_colsel", 32'(ColSelect), 32'h0);
    checkOutput("reset_data", FrameData, 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ready", 32'(s_ready), 32'h0);
`ifdef CFG_WRITER_CHECKSUM_EN
    checkOutput("reset_checksum", checksum, 32'h0);
`endif
    resetn = 1'b1;
    @(posedge CLK); #1;

    // First word timing: SETUP, single strobe cycle, HOLD, back to WAIT.
    pulseStart();
    checkOutput("wait_ready", 32'(s_ready), 32'd1);
    applyStimulus(32'hDEADBEEF, 1'b1);
    s_valid = 1'b0;
    checkOutput("setup_strobe", 32'(FrameStrobe), 32'h0);
    checkOutput("setup_colsel", 32'(ColSelect), 32'h01);
    checkOutput("setup_data", FrameData, 32'hDEADBEEF);
    checkOutput("setup_busy", 32'(busy), 32'd1);
    checkOutput("setup_ready", 32'(s_ready), 32'd0);
    @(posedge CLK); #1;
    checkOutput("strobe_bits", 32'(FrameStrobe), 32'h00001);
    @(posedge CLK); #1;
    checkOutput("hold_strobe", 32'(FrameStrobe), 32'h0);
    checkOutput("hold_data", FrameData, 32'hDEADBEEF);
    checkOutput("hold_ready", 32'(s_ready), 32'd0);
    @(posedge CLK); #1;
    checkOutput("back_to_wait", 32'(s_ready), 32'd1);

    // Remaining 159 words of the full array with s_valid held high.
    for (int i = 1; i < 160; i++) begin
      t = 16'(i);
      applyStimulus({t, ~t}, 1'b1);
    end
    s_valid = 1'b0;
    waitIdle();
    checkOutput("idle_ready", 32'(s_ready), 32'd0);
    checkOutput("idle_colsel", 32'(ColSelect), 32'h0);

    // Restart requested during the strobe of frame 5.
    pulseStart();
    for (int f = 0; f < 5; f++) begin
      applyStimulus(32'h5000_0000 + 32'(f), 1'b1);
    end
    applyStimulus(32'h5000_0005, 1'b1);
    s_valid = 1'b0;
    @(posedge CLK); #1;
    checkOutput("frame5_strobe", 32'(FrameStrobe), 32'h00020);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    checkOutput("restart_hold_busy", 32'(busy), 32'd1);
    expCol = 0;
    expFrame = 0;
    @(posedge CLK); #1;
    checkOutput("restart_wait", 32'(s_ready), 32'd1);
    applyStimulus(32'h6000_0000, 1'b1);
    s_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Checksum accumulation after start.
    pulseStart();
    applyStimulus(32'h1, 1'b1);
`ifdef CFG_WRITER_CHECKSUM_EN
    checkOutput("checksum_w1", checksum, 32'h1);
`endif
    applyStimulus(32'h2, 1'b1);
`ifdef CFG_WRITER_CHECKSUM_EN
    checkOutput("checksum_w2", checksum, 32'h0);
`endif
    s_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // s_valid toggling while the writer is busy must not be consumed.
    applyStimulus(32'hA5A5_A5A5, 1'b1);
    s_data = 32'hBAD0_0001;
    @(posedge CLK); #1;
    s_valid = 1'b0;
    @(posedge CLK); #1;
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0002;
    @(posedge CLK); #1;
    s_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("toggle_still_wait", 32'(s_ready), 32'd1);
    checkOutput("toggle_data_kept", FrameData, 32'hA5A5_A5A5);

    // Asynchronous reset in the middle of a strobe.
    expStrobe = 20'(1) << expFrame;
    applyStimulus(32'h1234_5678, 1'b0);
    s_valid = 1'b0;
    @(posedge CLK); #1;
    checkOutput("pre_reset_strobe", 32'(FrameStrobe), 32'(expStrobe));
    resetn = 1'b0;
    #1;
    checkOutput("async_strobe", 32'(FrameStrobe), 32'h0);
    checkOutput("async_colsel", 32'(ColSelect), 32'h0);
    checkOutput("async_data", FrameData, 32'h0);
    checkOutput("async_busy", 32'(busy), 32'h0);
    @(posedge CLK); #1;
    resetn = 1'b1;
    s_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("post_reset_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    pulseStart();
    checkOutput("post_start_ready", 32'(s_ready), 32'd1);

    repeat (10) @(posedge CLK);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
